// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction issue controller: opcodes, ALU
// encodings, sequencing states and instruction field positions.
package cpu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    READ   = 2'd2,
    WB     = 2'd3
  } state_e;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 24;
  localparam int DST_MSB  = 23;
  localparam int DST_LSB  = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_MSB = 7;
  localparam int SRC2_LSB = 0;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode/field decode: ALU controls, register addresses and a
// legality flag covering unknown opcodes and out-of-range register fields.
module instr_decode
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 3
) (
  input  logic [31:0]           instr,
  output logic [2:0]            aluop,
  output logic                  imm_sel,
  output logic                  neg_sel,
  output logic [REG_ADDR_W-1:0] rd1,
  output logic [REG_ADDR_W-1:0] rd2,
  output logic [REG_ADDR_W-1:0] wr,
  output logic                  illegal
);

  logic [7:0] opc;
  logic [7:0] dst;
  logic [7:0] src1;
  logic [7:0] src2;
  logic       dst_bad;
  logic       src1_bad;
  logic       src2_bad;

  always_comb begin
    opc  = instr[OPC_MSB:OPC_LSB];
    dst  = instr[DST_MSB:DST_LSB];
    src1 = instr[SRC1_MSB:SRC1_LSB];
    src2 = instr[SRC2_MSB:SRC2_LSB];

    // any bit above the register address width makes a field out of range
    dst_bad  = |(dst >> REG_ADDR_W);
    src1_bad = |(src1 >> REG_ADDR_W);
    src2_bad = |(src2 >> REG_ADDR_W);

    rd1     = src1[REG_ADDR_W-1:0];
    rd2     = src2[REG_ADDR_W-1:0];
    wr      = dst[REG_ADDR_W-1:0];
    aluop   = ALU_FWD;
    imm_sel = 1'b0;
    neg_sel = 1'b0;
    illegal = 1'b0;

    case (opc)
      OP_LOADI: begin
        imm_sel = 1'b1;
        illegal = dst_bad;
      end
      OP_MOV: begin
        illegal = dst_bad | src2_bad;
      end
      OP_ADD: begin
        aluop   = ALU_ADD;
        illegal = dst_bad | src1_bad | src2_bad;
      end
      OP_SUB: begin
        aluop   = ALU_ADD;
        neg_sel = 1'b1;
        illegal = dst_bad | src1_bad | src2_bad;
      end
      OP_AND: begin
        aluop   = ALU_AND;
        illegal = dst_bad | src1_bad | src2_bad;
      end
      OP_OR: begin
        aluop   = ALU_OR;
        illegal = dst_bad | src1_bad | src2_bad;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issues register-file read/write control for one instruction at a time
// through IDLE -> DECODE -> READ -> WB, and counts retired instructions.
module instr_issue_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int COUNT_W    = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  INSTR_VALID,
  input  logic [31:0]           INSTRUCTION,
  output logic                  INSTR_READY,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic                  WRITEENABLE,
  output logic [2:0]            ALUOP,
  output logic                  IMM_SEL,
  output logic                  NEG_SEL,
  output logic [7:0]            IMMEDIATE,
  output logic                  ILLEGAL,
  output logic [COUNT_W-1:0]    RETIRED_COUNT
);

  state_e                  state_q, state_d;
  logic [REG_ADDR_W-1:0]   rd1_q, rd1_d;
  logic [REG_ADDR_W-1:0]   rd2_q, rd2_d;
  logic [REG_ADDR_W-1:0]   wr_q, wr_d;
  logic                    we_q, we_d;
  logic [2:0]              aluop_q, aluop_d;
  logic                    imm_sel_q, imm_sel_d;
  logic                    neg_sel_q, neg_sel_d;
  logic [7:0]              imm_q, imm_d;
  logic                    illegal_q, illegal_d;
  logic [COUNT_W-1:0]      count_q, count_d;

  logic [2:0]              dec_aluop;
  logic                    dec_imm_sel;
  logic                    dec_neg_sel;
  logic [REG_ADDR_W-1:0]   dec_rd1;
  logic [REG_ADDR_W-1:0]   dec_rd2;
  logic [REG_ADDR_W-1:0]   dec_wr;
  logic                    dec_illegal;

  // Decoding the word at the handshake lets ILLEGAL be a registered pulse
  // that lines up exactly with the DECODE cycle.
  instr_decode #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_decode (
    .instr   (INSTRUCTION),
    .aluop   (dec_aluop),
    .imm_sel (dec_imm_sel),
    .neg_sel (dec_neg_sel),
    .rd1     (dec_rd1),
    .rd2     (dec_rd2),
    .wr      (dec_wr),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    rd1_d     = rd1_q;
    rd2_d     = rd2_q;
    wr_d      = wr_q;
    aluop_d   = aluop_q;
    imm_sel_d = imm_sel_q;
    neg_sel_d = neg_sel_q;
    imm_d     = imm_q;
    count_d   = count_q;
    we_d      = 1'b0;
    illegal_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (INSTR_VALID) begin
          state_d   = DECODE;
          illegal_d = dec_illegal;
          if (!dec_illegal) begin
            rd1_d     = dec_rd1;
            rd2_d     = dec_rd2;
            wr_d      = dec_wr;
            aluop_d   = dec_aluop;
            imm_sel_d = dec_imm_sel;
            neg_sel_d = dec_neg_sel;
            imm_d     = INSTRUCTION[SRC2_MSB:SRC2_LSB];
          end
        end
      end
      DECODE: begin
        state_d = illegal_q ? IDLE : READ;
      end
      READ: begin
        state_d = WB;
        we_d    = 1'b1;
      end
      WB: begin
        state_d = IDLE;
        count_d = count_q + COUNT_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      rd1_q     <= '0;
      rd2_q     <= '0;
      wr_q      <= '0;
      we_q      <= 1'b0;
      aluop_q   <= '0;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      wr_q      <= wr_d;
      we_q      <= we_d;
      aluop_q   <= aluop_d;
      imm_sel_q <= imm_sel_d;
      neg_sel_q <= neg_sel_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Outputs are forced low for the whole time RESET is high, not only after
  // the first reset edge.
  assign INSTR_READY   = ~RESET & (state_q == IDLE);
  assign READREG1      = RESET ? '0 : rd1_q;
  assign READREG2      = RESET ? '0 : rd2_q;
  assign WRITEREG      = RESET ? '0 : wr_q;
  assign WRITEENABLE   = ~RESET & we_q;
  assign ALUOP         = RESET ? '0 : aluop_q;
  assign IMM_SEL       = ~RESET & imm_sel_q;
  assign NEG_SEL       = ~RESET & neg_sel_q;
  assign IMMEDIATE     = RESET ? '0 : imm_q;
  assign ILLEGAL       = ~RESET & illegal_q;
  assign RETIRED_COUNT = RESET ? '0 : count_q;

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Self-checking bench for instr_issue_ctrl: directed vector table, multi-cycle
// corner sequences and a randomized run against an event-scheduled model.
module tb_instr_issue_ctrl;

  logic        CLK;
  logic        RESET;
  logic        INSTR_VALID;
  logic [31:0] INSTRUCTION;
  logic        INSTR_READY;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic [2:0]  WRITEREG;
  logic        WRITEENABLE;
  logic [2:0]  ALUOP;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic [7:0]  IMMEDIATE;
  logic        ILLEGAL;
  logic [7:0]  RETIRED_COUNT;

  int total = 0;
  int bad   = 0;

  instr_issue_ctrl #(.REG_ADDR_W(3), .COUNT_W(8)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .INSTR_VALID   (INSTR_VALID),
    .INSTRUCTION   (INSTRUCTION),
    .INSTR_READY   (INSTR_READY),
    .READREG1      (READREG1),
    .READREG2      (READREG2),
    .WRITEREG      (WRITEREG),
    .WRITEENABLE   (WRITEENABLE),
    .ALUOP         (ALUOP),
    .IMM_SEL       (IMM_SEL),
    .NEG_SEL       (NEG_SEL),
    .IMMEDIATE     (IMMEDIATE),
    .ILLEGAL       (ILLEGAL),
    .RETIRED_COUNT (RETIRED_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       ill;
    logic [2:0] aluop;
    logic       imm_sel;
    logic       neg_sel;
    logic [2:0] rr1;
    logic [2:0] rr2;
    logic [2:0] wr;
    logic [7:0] imm;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    dec_t        exp;
  } vec_t;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!INSTR_READY && n < 16) begin
      tick();
      n++;
    end
    if (!INSTR_READY) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: INSTR_READY still 0 after %0d cycles", n);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chkv({nm, "_lo"}, 32'({READREG1, READREG2, WRITEREG, WRITEENABLE, ALUOP,
                           IMM_SEL, NEG_SEL, IMMEDIATE, ILLEGAL}), 32'd0);
    chkv({nm, "_hi"}, 32'({INSTR_READY, RETIRED_COUNT}), 32'd0);
  endtask

  // Reference decode from the opcode table and field-range rules.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t r;
    int   op, d, s1, s2;
    bit   d_ok, s1_ok, s2_ok;
    op = int'(w >> 24);
    d  = int'((w >> 16) & 32'hFF);
    s1 = int'((w >> 8) & 32'hFF);
    s2 = int'(w & 32'hFF);
    d_ok  = d < 8;
    s1_ok = s1 < 8;
    s2_ok = s2 < 8;
    r = '0;
    r.rr1 = 3'(s1 % 8);
    r.rr2 = 3'(s2 % 8);
    r.wr  = 3'(d % 8);
    r.imm = 8'(s2);
    case (op)
      0: begin
        r.imm_sel = 1'b1;
        r.ill     = !d_ok;
      end
      1: r.ill = !(d_ok && s2_ok);
      2, 3, 4, 5: begin
        r.ill     = !(d_ok && s1_ok && s2_ok);
        r.aluop   = (op <= 3) ? 3'd1 : (op == 4) ? 3'd2 : 3'd3;
        r.neg_sel = (op == 3);
      end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [7:0] op, d, s1, s2;
    op = 8'($urandom_range(0, 7));
    if ($urandom_range(0, 15) == 0) op = 8'($urandom);
    d  = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
    s1 = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
    s2 = ($urandom_range(0, 11) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
    if (op == 8'h00) s2 = 8'($urandom);
    return {op, d, s1, s2};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] prev;
    wait_ready();
    prev = RETIRED_COUNT;
    INSTR_VALID = 1'b1;
    INSTRUCTION = v.instr;
    tick();
    INSTR_VALID = 1'($urandom_range(0, 1));
    INSTRUCTION = $urandom;
    chk1($sformatf("v%0d_dec_ready", idx), INSTR_READY, 1'b0);
    chk1($sformatf("v%0d_dec_illegal", idx), ILLEGAL, v.exp.ill);
    chk1($sformatf("v%0d_dec_we", idx), WRITEENABLE, 1'b0);
    if (v.exp.ill) begin
      tick();
      chk1($sformatf("v%0d_ill_ready", idx), INSTR_READY, 1'b1);
      chk1($sformatf("v%0d_ill_clear", idx), ILLEGAL, 1'b0);
      chk1($sformatf("v%0d_ill_we", idx), WRITEENABLE, 1'b0);
      chkv($sformatf("v%0d_ill_count", idx), 32'(RETIRED_COUNT), 32'(prev));
    end else begin
      tick();
      chkv($sformatf("v%0d_rd_ctrl", idx),
           32'({READREG1, READREG2, ALUOP, IMM_SEL, NEG_SEL, IMMEDIATE}),
           32'({v.exp.rr1, v.exp.rr2, v.exp.aluop, v.exp.imm_sel, v.exp.neg_sel, v.exp.imm}));
      chk1($sformatf("v%0d_rd_we", idx), WRITEENABLE, 1'b0);
      chk1($sformatf("v%0d_rd_ill", idx), ILLEGAL, 1'b0);
      tick();
      chk1($sformatf("v%0d_wb_we", idx), WRITEENABLE, 1'b1);
      chkv($sformatf("v%0d_wb_wreg", idx), 32'(WRITEREG), 32'(v.exp.wr));
      chkv($sformatf("v%0d_wb_ctrl", idx),
           32'({READREG1, READREG2, ALUOP, IMM_SEL, NEG_SEL}),
           32'({v.exp.rr1, v.exp.rr2, v.exp.aluop, v.exp.imm_sel, v.exp.neg_sel}));
      tick();
      chk1($sformatf("v%0d_done_ready", idx), INSTR_READY, 1'b1);
      chk1($sformatf("v%0d_done_we", idx), WRITEENABLE, 1'b0);
      chkv($sformatf("v%0d_done_count", idx), 32'(RETIRED_COUNT), 32'(prev + 8'd1));
    end
    INSTR_VALID = 1'b0;
  endtask

  task automatic issue_quiet(input logic [31:0] w);
    wait_ready();
    INSTR_VALID = 1'b1;
    INSTRUCTION = w;
    tick();
    INSTR_VALID = 1'b0;
    tick();
    tick();
    tick();
  endtask

  vec_t vecs[11];

  initial begin
    logic [31:0] words[3];
    logic [2:0]  wr_log[$];
    int          we_cyc[$];
    int          k;
    logic        rdy;
    int          t, ready_at, we_at, ill_at, cnt;
    dec_t        d, pend;

    vecs[0]  = '{32'h0004002A, '{1'b0, 3'd0, 1'b1, 1'b0, 3'd0, 3'd2, 3'd4, 8'h2A}};
    vecs[1]  = '{32'h03020001, '{1'b0, 3'd1, 1'b0, 1'b1, 3'd0, 3'd1, 3'd2, 8'h01}};
    vecs[2]  = '{32'h07010203, '{1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00}};
    vecs[3]  = '{32'h02090102, '{1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00}};
    vecs[4]  = '{32'h01030005, '{1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd5, 3'd3, 8'h05}};
    vecs[5]  = '{32'h02050607, '{1'b0, 3'd1, 1'b0, 1'b0, 3'd6, 3'd7, 3'd5, 8'h07}};
    vecs[6]  = '{32'h04000102, '{1'b0, 3'd2, 1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 8'h02}};
    vecs[7]  = '{32'h05070302, '{1'b0, 3'd3, 1'b0, 1'b0, 3'd3, 3'd2, 3'd7, 8'h02}};
    vecs[8]  = '{32'h01010009, '{1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00}};
    vecs[9]  = '{32'h04010801, '{1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00}};
    vecs[10] = '{32'h0003FF80, '{1'b0, 3'd0, 1'b1, 1'b0, 3'd7, 3'd0, 3'd3, 8'h80}};

    // Reset with a valid word pending: reset must win and latch nothing.
    RESET       = 1'b1;
    INSTR_VALID = 1'b1;
    INSTRUCTION = 32'h0004002A;
    tick();
    chk_all_zero("rst_cyc1");
    tick();
    chk_all_zero("rst_cyc2");
    RESET       = 1'b0;
    INSTR_VALID = 1'b0;
    #1;
    chk1("rst_release_ready", INSTR_READY, 1'b1);
    chkv("rst_release_count", 32'(RETIRED_COUNT), 32'd0);
    tick();
    chk1("rst_nothing_latched", INSTR_READY, 1'b1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Back-to-back adds with INSTR_VALID held high.
    words[0] = 32'h02010203;
    words[1] = 32'h02040506;
    words[2] = 32'h02070001;
    wait_ready();
    k = 0;
    INSTR_VALID = 1'b1;
    INSTRUCTION = words[0];
    for (int c = 0; c < 14; c++) begin
      rdy = INSTR_READY;
      tick();
      if (rdy && INSTR_VALID && k < 3) k++;
      if (WRITEENABLE) begin
        wr_log.push_back(WRITEREG);
        we_cyc.push_back(c);
        chkv("b2b_aluop", 32'(ALUOP), 32'd1);
      end
      if (INSTR_READY && k == 3) INSTR_VALID = 1'b0;
      INSTRUCTION = (INSTR_READY && k < 3) ? words[k] : 32'h02030000;
    end
    INSTR_VALID = 1'b0;
    chkv("b2b_nwrites", 32'(wr_log.size()), 32'd3);
    if (wr_log.size() == 3) begin
      chkv("b2b_wr0", 32'(wr_log[0]), 32'd1);
      chkv("b2b_wr1", 32'(wr_log[1]), 32'd4);
      chkv("b2b_wr2", 32'(wr_log[2]), 32'd7);
      chkv("b2b_first_we", 32'(we_cyc[0]), 32'd2);
      chkv("b2b_gap01", 32'(we_cyc[1] - we_cyc[0]), 32'd4);
      chkv("b2b_gap12", 32'(we_cyc[2] - we_cyc[1]), 32'd4);
    end

    // Reset asserted in the READ cycle of an or instruction.
    wait_ready();
    INSTR_VALID = 1'b1;
    INSTRUCTION = 32'h05050102;
    tick();
    INSTR_VALID = 1'b0;
    tick();
    chkv("mid_read_aluop", 32'(ALUOP), 32'd3);
    chk1("mid_read_we", WRITEENABLE, 1'b0);
    RESET = 1'b1;
    #1;
    chk_all_zero("mid_rst_during");
    tick();
    chk1("mid_rst_we", WRITEENABLE, 1'b0);
    RESET = 1'b0;
    #1;
    chk1("mid_rst_ready", INSTR_READY, 1'b1);
    chkv("mid_rst_count", 32'(RETIRED_COUNT), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk1("mid_rst_no_we", WRITEENABLE, 1'b0);
      chkv("mid_rst_count_hold", 32'(RETIRED_COUNT), 32'd0);
    end

    // Counter wrap after 256 retired loadi.
    for (int i = 0; i < 255; i++) issue_quiet(32'h00010005);
    chkv("wrap_255", 32'(RETIRED_COUNT), 32'd255);
    issue_quiet(32'h00010005);
    chkv("wrap_0", 32'(RETIRED_COUNT), 32'd0);

    // Randomized run against an event-scheduled model.
    RESET       = 1'b1;
    INSTR_VALID = 1'b0;
    tick();
    t        = 0;
    ready_at = 0;
    we_at    = -10;
    ill_at   = -10;
    cnt      = 0;
    pend     = '0;
    for (int i = 0; i < 600; i++) begin
      RESET       = ($urandom_range(0, 49) == 0);
      INSTR_VALID = ($urandom_range(0, 2) != 0);
      INSTRUCTION = gen_instr();
      tick();
      t++;
      if (RESET) begin
        cnt      = 0;
        ready_at = t;
        we_at    = -10;
        ill_at   = -10;
      end else begin
        if (t == we_at + 1) cnt = (cnt + 1) % 256;
        if (INSTR_VALID && (t - 1) >= ready_at) begin
          d = ref_decode(INSTRUCTION);
          if (d.ill) begin
            ill_at   = t;
            ready_at = t + 1;
          end else begin
            pend     = d;
            we_at    = t + 2;
            ready_at = t + 3;
          end
        end
      end
      chk1("rnd_ready", INSTR_READY, !RESET && t >= ready_at);
      chk1("rnd_we", WRITEENABLE, !RESET && t == we_at);
      chk1("rnd_illegal", ILLEGAL, !RESET && t == ill_at);
      chkv("rnd_count", 32'(RETIRED_COUNT), 32'(RESET ? 0 : cnt));
      if (!RESET && (t == we_at || t == we_at - 1)) begin
        chkv("rnd_ctrl",
             32'({READREG1, READREG2, ALUOP, IMM_SEL, NEG_SEL, IMMEDIATE}),
             32'({pend.rr1, pend.rr2, pend.aluop, pend.imm_sel, pend.neg_sel, pend.imm}));
        if (t == we_at) chkv("rnd_wreg", 32'(WRITEREG), 32'(pend.wr));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_issue_ctrl.md
Name: instr_issue_ctrl

Overview:
- Initiator-side control block that issues the read and write transactions the 8x8 register file responds to.
- Accepts one 32-bit instruction per valid/ready handshake and decodes it.
- Drives the register-file read addresses, write address and write enable, plus ALU and operand-select controls, through a fixed 4-state sequence.
- Sits between the instruction fetch path and the register file / ALU datapath in the CPU.

Parameters:
- REG_ADDR_W, 3, register address width (8 registers).
- COUNT_W, 8, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
- INSTR_VALID  input  1  INSTRUCTION holds a valid word.
- INSTRUCTION  input  32  fields: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2 or immediate.
- INSTR_READY  output  1  block can accept an instruction this cycle.
- READREG1  output  REG_ADDR_W  register-file OUT1 address.
- READREG2  output  REG_ADDR_W  register-file OUT2 address.
- WRITEREG  output  REG_ADDR_W  register-file write address.
- WRITEENABLE  output  1  register-file WRITE strobe.
- ALUOP  output  3  000 FORWARD, 001 ADD, 010 AND, 011 OR.
- IMM_SEL  output  1  ALU operand 2 = IMMEDIATE instead of OUT2.
- NEG_SEL  output  1  ALU operand 2 = two's complement of OUT2.
- IMMEDIATE  output  8  immediate field of the latched instruction.
- ILLEGAL  output  1  one-cycle pulse on an undecodable instruction.
- RETIRED_COUNT  output  COUNT_W  number of instructions written back.

Behaviour:
- Reset: synchronous, active-high; one clock; state IDLE.
  - While RESET=1: every output is 0, including INSTR_READY.
  - After reset: INSTR_READY=1 in the first cycle with RESET=0.
- Reset mid-operation: the in-flight instruction is abandoned with no write, and RETIRED_COUNT clears.
- Opcodes (all others illegal):
  - 0x00 loadi: ALUOP=FORWARD, IMM_SEL=1.
  - 0x01 mov: ALUOP=FORWARD, READREG2=[2:0].
  - 0x02 add: ALUOP=ADD.
  - 0x03 sub: ALUOP=ADD, NEG_SEL=1.
  - 0x04 and: ALUOP=AND.
  - 0x05 or: ALUOP=OR.
- Register field mapping: READREG1=[10:8], READREG2=[2:0], WRITEREG=[18:16].
- Legality: the unused upper bits of every used register field must be 0, otherwise the instruction is illegal.
  - dest [23:19] always.
  - src1 [15:11] for add/sub/and/or.
  - src2 [7:3] for mov/add/sub/and/or.
  - loadi treats [7:0] as the immediate; the src1 field is ignored.
- FSM:
  - IDLE: INSTR_READY=1. If INSTR_VALID=1 at posedge, latch INSTRUCTION and go to DECODE; otherwise stay.
  - DECODE (1 cycle): register the decoded controls. Illegal: ILLEGAL=1 for this cycle, next state IDLE, no write. Legal: next state READ.
  - READ (1 cycle): READREG1/2, ALUOP, IMM_SEL, NEG_SEL, IMMEDIATE valid and stable; WRITEENABLE=0. This cycle lets register-file and ALU data settle.
  - WB (1 cycle): WRITEENABLE=1, WRITEREG valid. The register file captures at the posedge ending WB. RETIRED_COUNT increments at that edge. Next state IDLE.
- Control outputs hold their values from DECODE exit through WB.
  - In IDLE they keep their last values, except WRITEENABLE=0 and ILLEGAL=0.
- Latency and throughput:
  - Handshake at edge N; register-file write at edge N+3; INSTR_READY again in cycle N+3.
  - Peak throughput is 1 instruction per 4 cycles; an illegal instruction costs 2 cycles.
- INSTR_READY=0 outside IDLE; INSTR_VALID is ignored there, and INSTRUCTION changes have no effect after latching.
- RETIRED_COUNT wraps 2^COUNT_W-1 -> 0. Illegal instructions do not count.
- Simultaneous RESET=1 and INSTR_VALID=1: reset wins and nothing is latched.

Decomposition:
- Shared package (cpu_pkg):
  - opcode constants: OP_LOADI..OP_OR.
  - ALUOP encodings.
  - state typedef: IDLE/DECODE/READ/WB.
  - instruction field bit positions.
- One natural combinational sub-module, instr_decode: opcode plus fields in, {ALUOP, IMM_SEL, NEG_SEL, READREG1/2, WRITEREG, illegal} out.
- instr_issue_ctrl keeps the FSM, instruction latch, handshake and counter.

Test Plan:
- Reset then idle: RESET=1 for 2 cycles, then 0 -> all outputs 0 during reset; INSTR_READY=1 on the first cycle after; RETIRED_COUNT=0.
- loadi 0x00_04_00_2A accepted at edge N -> IMM_SEL=1, ALUOP=000, IMMEDIATE=0x2A, WRITEREG=4; WRITEENABLE=1 only in cycle N+2; RETIRED_COUNT=1 after edge N+3.
- sub 0x03_02_00_01 -> READREG1=0, READREG2=1, ALUOP=001, NEG_SEL=1, WRITEREG=2; exactly one WRITEENABLE pulse.
- Illegal 0x07_01_02_03 and dest-field violation 0x02_09_01_02 -> one-cycle ILLEGAL pulse each; no WRITEENABLE; RETIRED_COUNT unchanged; INSTR_READY back 2 cycles after accept.
- Back-to-back: INSTR_VALID held high with 3 different add words -> accepted at 4-cycle spacing; INSTR_VALID ignored while INSTR_READY=0; 3 writes in order.
- RESET asserted in the READ cycle of an or instruction -> no WRITEENABLE pulse; state IDLE; RETIRED_COUNT=0. Separately, 256 retired loadi -> RETIRED_COUNT wraps to 0.
